// File: rtl/sys_ctrl_mb.sv
// sys_ctrl_mb: UART command-frame controller sequencing RF writes/reads and ALU operations,
// returning results byte-wise to the TX FIFO. Define SYS_CTRL_TIMEOUT_EN for the inter-byte frame timeout.
module sys_ctrl_mb #(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       ADDR_W      = 4,
   parameter int unsigned       ALU_W       = 16,
   parameter int unsigned       FUN_W       = 4,
   parameter int unsigned       OPA_ADDR    = 0,
   parameter int unsigned       OPB_ADDR    = 1,
   parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
   parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB,
   parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
   parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD,
   parameter int unsigned       TIMEOUT_CYC = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] RX_DATA,
   input  logic              RX_VLD,
   input  logic              FIFO_FULL,
   input  logic [DATA_W-1:0] RF_RD_DATA,
   input  logic              RF_RD_VLD,
   input  logic [ALU_W-1:0]  ALU_OUT,
   input  logic              ALU_OUT_VLD,
   output logic              RF_WR_EN,
   output logic              RF_RD_EN,
   output logic [ADDR_W-1:0] RF_ADDR,
   output logic [DATA_W-1:0] RF_WR_DATA,
   output logic              ALU_EN,
   output logic [FUN_W-1:0]  ALU_FUN,
   output logic              CLKG_EN,
   output logic              CLKDIV_EN,
   output logic [DATA_W-1:0] TX_DATA,
   output logic              TX_VLD,
   output logic              BUSY,
   output logic              ERR
);

   localparam int unsigned NBYTES = ALU_W / DATA_W;
   localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   // Reject configurations the byte serialiser or the timeout cannot handle.
   if ((ALU_W % DATA_W) != 0 || NBYTES == 0 || TIMEOUT_CYC == 0) begin : g_param_chk
      $error("sys_ctrl_mb: ALU_W must be a non-zero multiple of DATA_W and TIMEOUT_CYC > 0");
   end

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      TX_RF    = 4'd5,
      OP_A     = 4'd6,
      OP_B     = 4'd7,
      FUN      = 4'd8,
      ALU_WAIT = 4'd9,
      TX_ALU   = 4'd10
   } state_t;

   state_t            state_q,      state_d;
   logic              rf_wr_en_q,   rf_wr_en_d;
   logic              rf_rd_en_q,   rf_rd_en_d;
   logic [ADDR_W-1:0] rf_addr_q,    rf_addr_d;
   logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
   logic              alu_en_q,     alu_en_d;
   logic [FUN_W-1:0]  alu_fun_q,    alu_fun_d;
   logic              clkg_en_q,    clkg_en_d;
   logic [DATA_W-1:0] tx_data_q,    tx_data_d;
   logic              tx_vld_q,     tx_vld_d;
   logic              busy_q,       busy_d;
   logic [DATA_W-1:0] rd_buf_q,     rd_buf_d;
   logic [ALU_W-1:0]  res_q,        res_d;
   logic [IDX_W-1:0]  idx_q,        idx_d;

`ifdef SYS_CTRL_TIMEOUT_EN
   localparam int unsigned TO_CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

   logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic                err_q,    err_d;
   logic                wait_st_s;

   assign wait_st_s = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                      (state_q == OP_A)    || (state_q == OP_B)    || (state_q == FUN);
`endif

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      alu_en_d     = 1'b0;
      alu_fun_d    = alu_fun_q;
      tx_vld_d     = 1'b0;
      tx_data_d    = tx_data_q;
      rd_buf_d     = rd_buf_q;
      res_d        = res_q;
      idx_d        = idx_q;
      case (state_q)
         IDLE: begin
            if (RX_VLD) begin
               case (RX_DATA)
                  CMD_WR:      state_d = WR_ADDR;
                  CMD_RD:      state_d = RD_ADDR;
                  CMD_ALU_OP:  state_d = OP_A;
                  CMD_ALU_NOP: state_d = FUN;
                  default:     state_d = IDLE;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         WR_ADDR: begin
            if (RX_VLD) begin
               rf_addr_d = RX_DATA[ADDR_W-1:0];
               state_d   = WR_DATA;
            end else begin
               state_d = WR_ADDR;
            end
         end
         WR_DATA: begin
            if (RX_VLD) begin
               rf_wr_en_d   = 1'b1;
               rf_wr_data_d = RX_DATA;
               state_d      = IDLE;
            end else begin
               state_d = WR_DATA;
            end
         end
         RD_ADDR: begin
            if (RX_VLD) begin
               rf_addr_d  = RX_DATA[ADDR_W-1:0];
               rf_rd_en_d = 1'b1;
               state_d    = RD_WAIT;
            end else begin
               state_d = RD_ADDR;
            end
         end
         RD_WAIT: begin
            if (RF_RD_VLD) begin
               rd_buf_d = RF_RD_DATA;
               state_d  = TX_RF;
            end else begin
               state_d = RD_WAIT;
            end
         end
         TX_RF: begin
            if (!FIFO_FULL) begin
               tx_vld_d  = 1'b1;
               tx_data_d = rd_buf_q;
               state_d   = IDLE;
            end else begin
               state_d = TX_RF;
            end
         end
         OP_A: begin
            if (RX_VLD) begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_W'(OPA_ADDR);
               rf_wr_data_d = RX_DATA;
               state_d      = OP_B;
            end else begin
               state_d = OP_A;
            end
         end
         OP_B: begin
            if (RX_VLD) begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_W'(OPB_ADDR);
               rf_wr_data_d = RX_DATA;
               state_d      = FUN;
            end else begin
               state_d = OP_B;
            end
         end
         FUN: begin
            if (RX_VLD) begin
               alu_en_d  = 1'b1;
               alu_fun_d = RX_DATA[FUN_W-1:0];
               state_d   = ALU_WAIT;
            end else begin
               state_d = FUN;
            end
         end
         ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
               res_d   = ALU_OUT;
               idx_d   = '0;
               state_d = TX_ALU;
            end else begin
               state_d = ALU_WAIT;
            end
         end
         TX_ALU: begin
            // Least-significant byte first; index only advances on an accepted write.
            if (!FIFO_FULL) begin
               tx_vld_d  = 1'b1;
               tx_data_d = res_q[idx_q*DATA_W +: DATA_W];
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = TX_ALU;
               end
            end else begin
               state_d = TX_ALU;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef SYS_CTRL_TIMEOUT_EN
      err_d    = 1'b0;
      to_cnt_d = '0;
      // No byte arrived this cycle: the abort path issues no strobe since none was set above.
      if (wait_st_s && !RX_VLD) begin
         if (to_cnt_q == TO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TO_CNT_W'(1);
         end
      end else begin
         to_cnt_d = '0;
      end
`endif

      busy_d    = (state_d != IDLE);
      clkg_en_d = (state_d == FUN) || (state_d == ALU_WAIT) || (state_d == TX_ALU);
   end

   // State, buffers and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         rf_wr_en_q   <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         rf_addr_q    <= '0;
         rf_wr_data_q <= '0;
         alu_en_q     <= 1'b0;
         alu_fun_q    <= '0;
         clkg_en_q    <= 1'b0;
         tx_data_q    <= '0;
         tx_vld_q     <= 1'b0;
         busy_q       <= 1'b0;
         rd_buf_q     <= '0;
         res_q        <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_rd_en_q   <= rf_rd_en_d;
         rf_addr_q    <= rf_addr_d;
         rf_wr_data_q <= rf_wr_data_d;
         alu_en_q     <= alu_en_d;
         alu_fun_q    <= alu_fun_d;
         clkg_en_q    <= clkg_en_d;
         tx_data_q    <= tx_data_d;
         tx_vld_q     <= tx_vld_d;
         busy_q       <= busy_d;
         rd_buf_q     <= rd_buf_d;
         res_q        <= res_d;
         idx_q        <= idx_d;
      end
   end

`ifdef SYS_CTRL_TIMEOUT_EN
   // Inter-byte timeout counter and abort pulse.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   assign RF_WR_EN   = rf_wr_en_q;
   assign RF_RD_EN   = rf_rd_en_q;
   assign RF_ADDR    = rf_addr_q;
   assign RF_WR_DATA = rf_wr_data_q;
   assign ALU_EN     = alu_en_q;
   assign ALU_FUN    = alu_fun_q;
   assign CLKG_EN    = clkg_en_q;
   assign CLKDIV_EN  = 1'b1;
   assign TX_DATA    = tx_data_q;
   assign TX_VLD     = tx_vld_q;
   assign BUSY       = busy_q;

endmodule
